// File: rtl/cache_sa_pkg.sv
// rtl/cache_sa_pkg.sv - shared FSM encodings and helpers for the set-associative cache
// Purpose: FSM state constants (COMP/ALLC/WB) and a constant-evaluable clog2.
// Ports:   none (package).
package cache_sa_pkg;

  localparam logic [1:0] ST_COMP = 2'd0;  // compare tags, serve hits
  localparam logic [1:0] ST_ALLC = 2'd1;  // line fill from memory
  localparam logic [1:0] ST_WB   = 2'd2;  // dirty victim write-back

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/cache_sa_way.sv
// rtl/cache_sa_way.sv - one way of the set-associative cache
// Purpose: per-set valid/dirty/tag/line storage for a single way, tag compare
//          and word write. Fill has priority over a word write.
// Ports:   i_clk, i_rst_n (async, active low, clears valid/dirty only)
//          i_idx/i_tag/i_off    lookup address fields
//          i_wr, i_wdata        write-hit word update (sets dirty)
//          i_fill, i_fill_line  line install (valid=1, dirty=0)
//          o_hit, o_valid, o_dirty, o_tag, o_line, o_word  lookup results for set i_idx
module cache_sa_way
  import cache_sa_pkg::*;
#(
  parameter int SETS   = 4,
  parameter int WORDS  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 26,
  parameter int IDX_W  = 2,
  parameter int OFF_W  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [IDX_W-1:0]        i_idx,
  input  logic [TAG_W-1:0]        i_tag,
  input  logic [OFF_W-1:0]        i_off,
  input  logic                    i_wr,
  input  logic [DATA_W-1:0]       i_wdata,
  input  logic                    i_fill,
  input  logic [WORDS*DATA_W-1:0] i_fill_line,
  output logic                    o_hit,
  output logic                    o_valid,
  output logic                    o_dirty,
  output logic [TAG_W-1:0]        o_tag,
  output logic [WORDS*DATA_W-1:0] o_line,
  output logic [DATA_W-1:0]       o_word
);

  logic [SETS-1:0]         r_valid;
  logic [SETS-1:0]         r_dirty;
  logic [TAG_W-1:0]        r_tag  [SETS];
  logic [WORDS*DATA_W-1:0] r_line [SETS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_wr) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid gates every use of them.
  always_ff @(posedge i_clk) begin
    if (i_fill) begin
      r_tag[i_idx]  <= i_tag;
      r_line[i_idx] <= i_fill_line;
    end else if (i_wr) begin
      r_line[i_idx][DATA_W*int'(i_off) +: DATA_W] <= i_wdata;
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_line  = r_line[i_idx];
  assign o_word  = r_line[i_idx][DATA_W*int'(i_off) +: DATA_W];
  assign o_hit   = r_valid[i_idx] && (r_tag[i_idx] == i_tag);

endmodule

// File: rtl/cache_sa.sv
// rtl/cache_sa.sv - N-way set-associative write-back write-allocate cache
// Purpose: processor-side single-word cache with stall handshake, line-wide
//          memory side with ready handshake, round-robin replacement.
// Ports:   clk, proc_reset_n (async, active low)
//          proc_read/proc_write/proc_addr/proc_wdata -> proc_rdata/proc_stall
//          mem_read/mem_write/mem_addr/mem_wdata     <- mem_rdata/mem_ready
//          stat_hit/stat_miss only when CACHE_STATS_EN is defined
module cache_sa
  import cache_sa_pkg::*;
#(
  parameter int WAYS   = 2,
  parameter int SETS   = 4,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic                              clk,
  input  logic                              proc_reset_n,
  input  logic                              proc_read,
  input  logic                              proc_write,
  input  logic [ADDR_W-1:0]                 proc_addr,
  input  logic [DATA_W-1:0]                 proc_wdata,
  output logic [DATA_W-1:0]                 proc_rdata,
  output logic                              proc_stall,
  output logic                              mem_read,
  output logic                              mem_write,
  output logic [ADDR_W-clog2(WORDS)-1:0]    mem_addr,
  output logic [WORDS*DATA_W-1:0]           mem_wdata,
  input  logic [WORDS*DATA_W-1:0]           mem_rdata,
  input  logic                              mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                       stat_hit,
  output logic [31:0]                       stat_miss
`endif
);

  localparam int OFF_W   = clog2(WORDS);
  localparam int IDX_W   = clog2(SETS);
  localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
  localparam int MADDR_W = ADDR_W - OFF_W;
  localparam int LINE_W  = WORDS * DATA_W;
  localparam int PTR_W   = (WAYS > 1) ? clog2(WAYS) : 1;

  logic [1:0]       r_state;
  logic [PTR_W-1:0] r_victim;
  logic [PTR_W-1:0] r_ptr [SETS];

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_req;
  logic             w_hit;
  logic             w_miss_start;
  logic             w_victim_dirty;
  logic [PTR_W-1:0] w_new_victim;
  logic [DATA_W-1:0] w_rdata;

  logic [WAYS-1:0]   w_way_hit;
  logic [WAYS-1:0]   w_way_valid;
  logic [WAYS-1:0]   w_way_dirty;
  logic [WAYS-1:0]   w_way_wr;
  logic [WAYS-1:0]   w_way_fill;
  logic [TAG_W-1:0]  w_way_tag  [WAYS];
  logic [LINE_W-1:0] w_way_line [WAYS];
  logic [DATA_W-1:0] w_way_word [WAYS];

  assign w_off = proc_addr[OFF_W-1:0];
  assign w_idx = proc_addr[OFF_W +: IDX_W];
  assign w_tag = proc_addr[ADDR_W-1 -: TAG_W];
  assign w_req = proc_read | proc_write;
  assign w_hit = |w_way_hit;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign w_way_wr[g]   = (r_state == ST_COMP) & proc_write & w_way_hit[g];
    assign w_way_fill[g] = (r_state == ST_ALLC) & mem_ready & (r_victim == PTR_W'(g));

    cache_sa_way #(
      .SETS  (SETS),
      .WORDS (WORDS),
      .DATA_W(DATA_W),
      .TAG_W (TAG_W),
      .IDX_W (IDX_W),
      .OFF_W (OFF_W)
    ) u_way (
      .i_clk      (clk),
      .i_rst_n    (proc_reset_n),
      .i_idx      (w_idx),
      .i_tag      (w_tag),
      .i_off      (w_off),
      .i_wr       (w_way_wr[g]),
      .i_wdata    (proc_wdata),
      .i_fill     (w_way_fill[g]),
      .i_fill_line(mem_rdata),
      .o_hit      (w_way_hit[g]),
      .o_valid    (w_way_valid[g]),
      .o_dirty    (w_way_dirty[g]),
      .o_tag      (w_way_tag[g]),
      .o_line     (w_way_line[g]),
      .o_word     (w_way_word[g])
    );
  end

  // At most one way hits, so OR-ing the gated words is a one-hot mux.
  always_comb begin
    w_rdata = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_way_hit[w]) w_rdata = w_rdata | w_way_word[w];
    end
  end
  assign proc_rdata = w_rdata;

  // Lowest invalid way wins; descending scan lets the smallest index overwrite.
  always_comb begin
    w_new_victim = r_ptr[w_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_way_valid[w]) w_new_victim = PTR_W'(w);
    end
  end
  assign w_victim_dirty = w_way_dirty[w_new_victim];
  assign w_miss_start   = (r_state == ST_COMP) & w_req & ~w_hit;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      r_state  <= ST_COMP;
      r_victim <= '0;
    end else begin
      case (r_state)
        ST_COMP: begin
          if (w_miss_start) begin
            r_victim <= w_new_victim;
            r_state  <= w_victim_dirty ? ST_WB : ST_ALLC;
          end
        end
        ST_WB:   if (mem_ready) r_state <= ST_ALLC;
        ST_ALLC: if (mem_ready) r_state <= ST_COMP;
        default: r_state <= ST_COMP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
    end else if (r_state == ST_ALLC && mem_ready) begin
      r_ptr[w_idx] <= (r_victim == PTR_W'(WAYS - 1)) ? '0 : r_victim + 1'b1;
    end
  end

  // Request strobes drop in the ready cycle; address/data follow the strobes.
  assign mem_write  = (r_state == ST_WB) & ~mem_ready;
  assign mem_read   = (r_state == ST_ALLC) & ~mem_ready;
  assign mem_addr   = mem_write ? MADDR_W'({w_way_tag[r_victim], w_idx}) :
                      mem_read  ? proc_addr[ADDR_W-1:OFF_W] : '0;
  assign mem_wdata  = mem_write ? w_way_line[r_victim] : '0;
  assign proc_stall = proc_reset_n & ((r_state != ST_COMP) | (w_req & ~w_hit));

`ifdef CACHE_STATS_EN
  logic [31:0] r_stat_hit;
  logic [31:0] r_stat_miss;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      r_stat_hit  <= '0;
      r_stat_miss <= '0;
    end else begin
      if ((r_state == ST_COMP) && w_req && w_hit && (r_stat_hit != 32'hFFFF_FFFF))
        r_stat_hit <= r_stat_hit + 32'd1;
      if (w_miss_start && (r_stat_miss != 32'hFFFF_FFFF))
        r_stat_miss <= r_stat_miss + 32'd1;
    end
  end

  assign stat_hit  = r_stat_hit;
  assign stat_miss = r_stat_miss;
`endif

endmodule
